mmio_initiator: RTL and testbench
=================================

Name: mmio_initiator

Overview:
- Bus initiator for the peripheral MMIO bus (req/wren/addr/wdata/wstrb out; gnt/rdata/rvalid in) used by the GPIO and other memory-mapped peripherals.
- Accepts one CPU load/store at a time over a valid/ready port.
- Drives the bus with lane-replicated write data and byte strobes, and waits for the response.
- Returns load data lane-extracted and sign- or zero-extended, and reports misalignment or timeout as an error.

Parameters:
ADDR_W, 12, width of cpu_addr and bus addr.
TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before aborting with error (>=2).

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
cpu_valid  in  1  CPU request valid
cpu_ready  out  1  high only in IDLE; accept when cpu_valid&cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address
cpu_size  in  2  0=byte,1=half,2=word,3=dword
cpu_signed  in  1  loads: 1=sign-extend, 0=zero-extend
cpu_wdata  in  64  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_rdata  out  64  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or timeout, valid with rsp_valid
req  out  1  bus request, registered
wren  out  1  bus write enable, registered
addr  out  ADDR_W  bus address, registered
gnt  in  1  bus grant
wdata  out  64  bus write data, registered
wstrb  out  8  bus byte strobes, registered
rdata  in  64  bus read data
rvalid  in  1  bus response valid

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rstn.
- Reset:
  - State goes to IDLE; cpu_ready=1.
  - req, wren, addr, wdata, wstrb, rsp_valid, rsp_rdata, rsp_err and the timeout counter are all 0.
  - Reset mid-transaction drops req immediately and discards the transaction; no response is ever produced for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, on accept:
  - Capture cpu_we, cpu_addr, cpu_size, cpu_signed.
  - Misaligned means addr mod (1<<size) != 0. Misaligned goes to RESP with err=1 and rdata=0, and issues no bus request.
  - Aligned goes to ISSUE. req=1 and addr/wren/wdata/wstrb are loaded in the same edge.
- Strobe and data rules (lo = addr[2:0]):
  - wstrb = (size0:0x01, size1:0x03, size2:0x0F, size3:0xFF) << lo, truncated to 8 bits.
  - wstrb is driven for loads too; responders ignore it.
  - wdata replicates the low 1<<size bytes of cpu_wdata across all 64 bits. size3 passes cpu_wdata unchanged.
- ISSUE:
  - req, addr, wren, wdata and wstrb stay stable until a cycle with gnt=1.
  - On req&gnt, req drops at the next edge and the state goes to WAIT.
- WAIT: on rvalid, capture the response and go to RESP.
  - Loads: shift rdata right by lo*8, keep the low 8<<size bits, then sign-extend from the top kept bit if cpu_signed, else zero-extend. size3 uses rdata unchanged.
  - Stores: rsp_rdata=0.
- Timeout:
  - The counter is cleared on accept and increments every cycle in ISSUE or WAIT.
  - When it reaches TIMEOUT with no gnt (ISSUE) or no rvalid (WAIT) that cycle, req drops and the state goes to RESP with err=1 and rdata=0.
  - If rvalid and the timeout occur in the same cycle, rvalid wins.
- RESP: rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_err, then IDLE. rsp_rdata and rsp_err hold until the next response.
- rvalid seen in IDLE, ISSUE or RESP is ignored and has no state change.
- Latency:
  - Accept at cycle T gives req high at T+1.
  - With gnt=1 at T+1 and the responder's rvalid at T+2, rsp_valid is high at T+3.
  - Misaligned accept at T gives rsp_valid at T+1.
- At most one outstanding transaction. The next accept is possible in the cycle after RESP.

Test Plan:
1. Store word 0x000000A5 to addr 0x00C, gnt=1 -> at T+1: req=1, wren=1, addr=0x00C, wstrb=0xF0, wdata=0x000000A5_000000A5. rvalid at T+2 -> rsp_valid at T+3, rsp_err=0, rsp_rdata=0.
2. Loads with rdata=0x00000080_00000080 returned:
   - word load addr 0x000 signed -> rsp_rdata=0x0000000000000080.
   - byte load addr 0x000 signed -> 0xFFFFFFFFFFFFFF80.
   - byte load addr 0x004 unsigned -> 0x80.
3. Store half 0xBEEF at addr 0x006 -> wstrb=0xC0, wdata=0xBEEFBEEF_BEEFBEEF. Store dword at 0x008 -> wstrb=0xFF.
4. Misaligned word load at 0x002 -> req never asserted, rsp_valid at T+1, rsp_err=1, rsp_rdata=0.
5. Stalls with TIMEOUT=8:
   - gnt low 5 cycles then high -> req and addr stable throughout ISSUE, normal completion.
   - gnt=1 but rvalid never asserts -> rsp_valid with rsp_err=1 after 8 counted cycles, then cpu_ready=1.
6. rstn asserted during WAIT -> req=0 and cpu_ready=1 immediately, no rsp_valid. A stray rvalid in IDLE is ignored. The next store completes normally.

Source files
------------

// File: rtl/mmio_initiator.sv
`default_nettype none
// mmio_initiator: single-outstanding CPU load/store bridge onto the peripheral MMIO bus,
// with lane-replicated writes, byte strobes, extended loads and a bus timeout.
module mmio_initiator #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [63:0]       cpu_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              req,
    output logic              wren,
    output logic [ADDR_W-1:0] addr,
    input  logic              gnt,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    input  logic [63:0]       rdata,
    input  logic              rvalid
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0]  TMO_LIM = (CNT_W + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          lo_q, lo_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic                req_q, req_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [7:0]          wstrb_q, wstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [63:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [2:0]          mis_mask;
    logic                misaligned;
    logic [7:0]          strb_base;
    logic [63:0]         wdata_rep;
    logic [63:0]         rd_shift;
    logic [63:0]         rd_ext;
    logic [CNT_W:0]      cnt_nxt;
    logic                expire;
    logic [CNT_W-1:0]    cnt_sat;

    // Request-side lane shaping, computed from the live CPU inputs at accept.
    always_comb begin
        mis_mask  = 3'b000;
        strb_base = 8'h01;
        wdata_rep = cpu_wdata;
        case (cpu_size)
            2'd0: begin
                mis_mask  = 3'b000;
                strb_base = 8'h01;
                wdata_rep = {8{cpu_wdata[7:0]}};
            end
            2'd1: begin
                mis_mask  = 3'b001;
                strb_base = 8'h03;
                wdata_rep = {4{cpu_wdata[15:0]}};
            end
            2'd2: begin
                mis_mask  = 3'b011;
                strb_base = 8'h0F;
                wdata_rep = {2{cpu_wdata[31:0]}};
            end
            default: begin
                mis_mask  = 3'b111;
                strb_base = 8'hFF;
                wdata_rep = cpu_wdata;
            end
        endcase
        misaligned = |(cpu_addr[2:0] & mis_mask);
    end

    always_comb begin
        rd_shift = rdata >> {lo_q, 3'b000};
        case (size_q)
            2'd0:    rd_ext = {{56{sgn_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    rd_ext = {{48{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    rd_ext = {{32{sgn_q & rd_shift[31]}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    // Saturating count of cycles spent in ISSUE+WAIT; expire on the TIMEOUT-th one.
    always_comb begin
        cnt_nxt = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        expire  = (cnt_nxt >= TMO_LIM);
        cnt_sat = expire ? TMO_LIM[CNT_W-1:0] : cnt_nxt[CNT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        lo_d        = lo_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        req_d       = req_q;
        wren_d      = wren_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    we_d   = cpu_we;
                    lo_d   = cpu_addr[2:0];
                    size_d = cpu_size;
                    sgn_d  = cpu_signed;
                    cnt_d  = '0;
                    if (misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 64'd0;
                    end else begin
                        state_d = ISSUE;
                        req_d   = 1'b1;
                        wren_d  = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = wdata_rep;
                        wstrb_d = strb_base << cpu_addr[2:0];
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_sat;
                if (gnt) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end else if (expire) begin
                    req_d       = 1'b0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 64'd0;
                end
            end
            WAIT: begin
                cnt_d = cnt_sat;
                if (rvalid) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 64'd0 : rd_ext;
                end else if (expire) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 64'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            lo_q        <= 3'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            req_q       <= 1'b0;
            wren_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 64'd0;
            wstrb_q     <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            lo_q        <= lo_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            req_q       <= req_d;
            wren_q      <= wren_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign req       = req_q;
    assign wren      = wren_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_initiator.sv
`default_nettype none
// tb_mmio_initiator: table-driven load/store vectors plus stall, timeout and reset sequences.
module tb_mmio_initiator;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 8;

    logic              clk;
    logic              rstn;
    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_size;
    logic              cpu_signed;
    logic [63:0]       cpu_wdata;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    logic              req;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic [63:0]       rdata;
    logic              rvalid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sgn;
        logic [63:0]       wdata;
        logic [63:0]       rdata;
        logic [7:0]        exp_strb;
        logic [63:0]       exp_wdata;
        logic [63:0]       exp_rdata;
        logic              exp_err;
    } vec_t;

    vec_t vecs[14];

    mmio_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_wdata  (cpu_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .req        (req),
        .wren       (wren),
        .addr       (addr),
        .gnt        (gnt),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rdata      (rdata),
        .rvalid     (rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic we, input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                          input logic sg, input logic [63:0] wd);
        @(negedge clk);
        chk("ready_before_accept", 64'(cpu_ready), 64'd1);
        cpu_valid  = 1'b1;
        cpu_we     = we;
        cpu_addr   = a;
        cpu_size   = sz;
        cpu_signed = sg;
        cpu_wdata  = wd;
        @(negedge clk);
        cpu_valid  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        accept(v.we, v.addr, v.size, v.sgn, v.wdata);
        if (v.exp_err) begin
            chk($sformatf("v%0d_mis_rsp_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("v%0d_mis_req", i), 64'(req), 64'd0);
            chk($sformatf("v%0d_mis_err", i), 64'(rsp_err), 64'd1);
            chk($sformatf("v%0d_mis_rdata", i), rsp_rdata, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_mis_pulse", i), 64'(rsp_valid), 64'd0);
            chk($sformatf("v%0d_mis_req2", i), 64'(req), 64'd0);
            chk($sformatf("v%0d_mis_ready", i), 64'(cpu_ready), 64'd1);
        end else begin
            chk($sformatf("v%0d_req", i), 64'(req), 64'd1);
            chk($sformatf("v%0d_wren", i), 64'(wren), 64'(v.we));
            chk($sformatf("v%0d_addr", i), 64'(addr), 64'(v.addr));
            chk($sformatf("v%0d_wstrb", i), 64'(wstrb), 64'(v.exp_strb));
            if (v.we) chk($sformatf("v%0d_wdata", i), wdata, v.exp_wdata);
            gnt = 1'b1;
            @(negedge clk);
            gnt = 1'b0;
            chk($sformatf("v%0d_req_drop", i), 64'(req), 64'd0);
            rvalid = 1'b1;
            rdata  = v.rdata;
            @(negedge clk);
            rvalid = 1'b0;
            chk($sformatf("v%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'd0);
            chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, v.exp_rdata);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_pulse", i), 64'(rsp_valid), 64'd0);
            chk($sformatf("v%0d_rsp_hold", i), rsp_rdata, v.exp_rdata);
            chk($sformatf("v%0d_ready_after", i), 64'(cpu_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            we    addr     sz    sg    cpu_wdata               bus rdata               strb   exp_wdata               exp_rdata               err
        vecs[0]  = '{1'b1, 12'h00C, 2'd2, 1'b0, 64'h0000_0000_0000_00A5, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, 64'h0000_00A5_0000_00A5, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 2'd2, 1'b1, 64'h0, 64'h0000_0080_0000_0080, 8'h0F, 64'h0, 64'h0000_0000_0000_0080, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 2'd0, 1'b1, 64'h0, 64'h0000_0080_0000_0080, 8'h01, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[3]  = '{1'b0, 12'h004, 2'd0, 1'b0, 64'h0, 64'h0000_0080_0000_0080, 8'h10, 64'h0, 64'h0000_0000_0000_0080, 1'b0};
        vecs[4]  = '{1'b1, 12'h006, 2'd1, 1'b0, 64'h1111_2222_3333_BEEF, 64'h0, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0, 1'b0};
        vecs[5]  = '{1'b1, 12'h008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[6]  = '{1'b0, 12'h002, 2'd1, 1'b1, 64'h0, 64'h0000_0000_8001_0000, 8'h0C, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
        vecs[7]  = '{1'b0, 12'h004, 2'd2, 1'b0, 64'h0, 64'hF000_0001_0000_0000, 8'hF0, 64'h0, 64'h0000_0000_F000_0001, 1'b0};
        vecs[8]  = '{1'b0, 12'h008, 2'd3, 1'b1, 64'h0, 64'h8000_0000_0000_0001, 8'hFF, 64'h0, 64'h8000_0000_0000_0001, 1'b0};
        vecs[9]  = '{1'b0, 12'h002, 2'd2, 1'b1, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{1'b1, 12'h003, 2'd1, 1'b0, 64'hFFFF, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[11] = '{1'b0, 12'h004, 2'd3, 1'b0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[12] = '{1'b0, 12'h007, 2'd0, 1'b1, 64'h0, 64'h7F00_0000_0000_0000, 8'h80, 64'h0, 64'h0000_0000_0000_007F, 1'b0};
        vecs[13] = '{1'b1, 12'h005, 2'd0, 1'b0, 64'h0000_0000_0000_00AB, 64'h0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0, 1'b0};

        rstn = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_size = 2'd0;
        cpu_signed = 1'b0; cpu_wdata = 64'd0; gnt = 1'b0; rdata = 64'd0; rvalid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(cpu_ready), 64'd1);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_wren", 64'(wren), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i);

        // gnt withheld for 5 cycles: request must hold steady, then complete normally.
        accept(1'b1, 12'h010, 2'd2, 1'b0, 64'h55);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_req_%0d", k), 64'(req), 64'd1);
            chk($sformatf("stall_addr_%0d", k), 64'(addr), 64'h010);
            chk($sformatf("stall_wdata_%0d", k), wdata, 64'h0000_0055_0000_0055);
            @(negedge clk);
        end
        chk("stall_req_last", 64'(req), 64'd1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("stall_req_drop", 64'(req), 64'd0);
        rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("stall_rsp_err", 64'(rsp_err), 64'd0);

        // rvalid never arrives: error response after TIMEOUT counted cycles.
        accept(1'b0, 12'h020, 2'd2, 1'b0, 64'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        for (int k = 2; k <= TIMEOUT; k++) begin
            chk($sformatf("tmo_wait_quiet_%0d", k), 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        chk("tmo_wait_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("tmo_wait_err", 64'(rsp_err), 64'd1);
        chk("tmo_wait_rdata", rsp_rdata, 64'd0);
        @(negedge clk);
        chk("tmo_wait_ready", 64'(cpu_ready), 64'd1);

        // gnt never arrives: req held until the limit, then dropped with error.
        accept(1'b1, 12'h030, 2'd3, 1'b0, 64'h1);
        for (int k = 1; k < TIMEOUT; k++) @(negedge clk);
        chk("tmo_issue_req_held", 64'(req), 64'd1);
        chk("tmo_issue_quiet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("tmo_issue_req_drop", 64'(req), 64'd0);
        chk("tmo_issue_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("tmo_issue_err", 64'(rsp_err), 64'd1);

        // Reset in WAIT discards the transaction; a stray rvalid afterwards is ignored.
        accept(1'b0, 12'h040, 2'd2, 1'b0, 64'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_req", 64'(req), 64'd0);
        chk("midrst_ready", 64'(cpu_ready), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_wstrb", 64'(wstrb), 64'd0);
        @(negedge clk);
        rstn   = 1'b1;
        rvalid = 1'b1;
        rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stray_rsp_valid_%0d", k), 64'(rsp_valid), 64'd0);
            chk($sformatf("stray_ready_%0d", k), 64'(cpu_ready), 64'd1);
            @(negedge clk);
        end
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
